// File: rtl/mlc_encode_scheduler.sv
// Shares one fixed-latency polar encoder across the NLEV bit levels of an MLC frame.
// Admission is credit-based because the encoder cannot stall.
module mlc_encode_scheduler #(
  parameter int unsigned N          = 256,
  parameter int unsigned NLEV       = 10,
  parameter int unsigned ENC_LAT    = 9,
  parameter int unsigned OBUF_DEPTH = 16,
  parameter int unsigned LW         = $clog2(NLEV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [N-1:0]  i_in_u,
  output logic          o_enc_valid_in,
  output logic [N-1:0]  o_enc_u,
  input  logic          i_enc_valid_out,
  input  logic [N-1:0]  i_enc_c,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [N-1:0]  o_out_c,
  output logic [LW-1:0] o_out_level,
  output logic          o_out_last,
  output logic          o_frame_done,
  output logic [15:0]   o_frames_cnt,
  output logic          o_err_tag,
  output logic          o_err_ovf
);

  localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [CW:0]   LIM      = (CW + 1)'(OBUF_DEPTH);
  localparam logic [CW-1:0] FULL_OCC = CW'(OBUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OBUF_DEPTH - 1);
  localparam logic [LW-1:0] LAST_LVL = LW'(NLEV - 1);

  logic                r_init;
  logic [LW-1:0]       r_level;
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_occ;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [ENC_LAT-1:0]  r_tag_vld;
  logic [LW-1:0]       r_tag_lvl [ENC_LAT];
  logic [N-1:0]        r_mem_c   [OBUF_DEPTH];
  logic [LW-1:0]       r_mem_lvl [OBUF_DEPTH];
  logic                r_frame_done;
  logic [15:0]         r_frames_cnt;
  logic                r_err_tag;
  logic                r_err_ovf;

  logic [CW:0] w_used;
  logic        w_accept;
  logic        w_tag_head;
  logic        w_full;
  logic        w_write;
  logic        w_pop;
  logic        w_enc_done;

  // Credits count both FIFO entries and words still inside the encoder.
  assign w_used     = {1'b0, r_occ} + {1'b0, r_inflight};
  assign o_in_ready = r_init & (w_used < LIM);
  assign w_accept   = i_in_valid & o_in_ready;

  assign o_enc_valid_in = w_accept;
  assign o_enc_u        = i_in_u;

  assign w_tag_head = r_tag_vld[ENC_LAT-1];
  assign w_full     = (r_occ == FULL_OCC);
  assign w_write    = i_enc_valid_out & w_tag_head & ~w_full;
  assign w_enc_done = i_enc_valid_out & (r_inflight != '0);

  assign o_out_valid  = (r_occ != '0);
  assign w_pop        = o_out_valid & i_out_ready;
  assign o_out_c      = r_mem_c[r_rd_ptr];
  assign o_out_level  = r_mem_lvl[r_rd_ptr];
  assign o_out_last   = o_out_valid & (o_out_level == LAST_LVL);
  assign o_frame_done = r_frame_done;
  assign o_frames_cnt = r_frames_cnt;
  assign o_err_tag    = r_err_tag;
  assign o_err_ovf    = r_err_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init       <= 1'b0;
      r_level      <= '0;
      r_inflight   <= '0;
      r_occ        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tag_vld    <= '0;
      r_frame_done <= 1'b0;
      r_frames_cnt <= '0;
      r_err_tag    <= 1'b0;
      r_err_ovf    <= 1'b0;
      for (int i = 0; i < ENC_LAT; i++) r_tag_lvl[i] <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_accept) r_level <= (r_level == LAST_LVL) ? '0 : r_level + 1'b1;

      r_tag_vld    <= {r_tag_vld[ENC_LAT-2:0], w_accept};
      r_tag_lvl[0] <= r_level;
      for (int i = 1; i < ENC_LAT; i++) r_tag_lvl[i] <= r_tag_lvl[i-1];

      unique case ({w_accept, w_enc_done})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      unique case ({w_write, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      if (w_write) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

      r_frame_done <= w_pop & o_out_last;
      if (w_pop & o_out_last) r_frames_cnt <= r_frames_cnt + 16'd1;

      if (i_enc_valid_out != w_tag_head) r_err_tag <= 1'b1;
      if (i_enc_valid_out & w_full)      r_err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem_c[i]   <= '0;
        r_mem_lvl[i] <= '0;
      end
    end else if (w_write) begin
      r_mem_c[r_wr_ptr]   <= i_enc_c;
      r_mem_lvl[r_wr_ptr] <= r_tag_lvl[ENC_LAT-1];
    end
  end

endmodule
